// File: rtl/chiptune_pkg.sv
// Shared types and constants for the APU register link.
package chiptune_pkg;
    localparam int          APU_ADDR_W       = 3;
    localparam int          CLKS_PER_BIT_DEF = 16;
    localparam logic [4:0]  SYNC_MARK        = 5'b10100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
endpackage

// File: rtl/apu_serial_tx_baud_gen.sv
// Free-running bit timer: generates sck and a one-cycle pulse ahead of each bit boundary.
// Latency: boundary is high in the last cycle of a bit; the boundary itself is the following edge.
// Backpressure: none, runs continuously and never restarts.
module baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    output logic sck,
    output logic boundary
);
    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF = CW'(CLKS_PER_BIT / 2);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // sck falls exactly where cnt wraps, so sdo updates land on sck falling edges
    assign sck      = (cnt >= HALF);
    assign boundary = (cnt == LAST);
endmodule

// File: rtl/apu_serial_tx.sv
// APU register-write serializer: two back-to-back UART-style frames ({SYNC,addr}, data) on sck/sdo.
// Latency: start bit begins on the first bit boundary strictly after the accept edge (1..CLKS_PER_BIT clks).
// Backpressure: wr_ready low while a write is in flight; ready again on the final stop-bit boundary edge.
module apu_serial_tx
    import chiptune_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [4:0] SYNC         = SYNC_MARK
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [APU_ADDR_W-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  wr_ready,
    output logic                  sck,
    output logic                  sdo,
    output logic                  busy
);
    tx_state_t  state, state_nxt;
    logic       boundary;
    logic       accept;
    logic [7:0] shreg;
    logic [7:0] data_hold;
    logic [2:0] bit_idx;
    logic       byte_sel;

    baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .boundary (boundary)
    );

    assign accept = wr_valid && wr_ready;
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // sdo is decoded from state, so it can only move when state moves on a boundary
    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        sdo       = 1'b1;
        case (state)
            ST_IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (boundary) state_nxt = ST_START;
            end
            ST_START: begin
                sdo = 1'b0;
                if (boundary) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                sdo = shreg[0];
                if (boundary && bit_idx == 3'd7) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (boundary) begin
                    if (!byte_sel) begin
                        state_nxt = ST_START;
                    end else begin
                        // closing edge of the write doubles as an accept slot for the next one
                        wr_ready  = 1'b1;
                        state_nxt = wr_valid ? ST_WAIT : ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg     <= '0;
            data_hold <= '0;
            bit_idx   <= '0;
            byte_sel  <= 1'b0;
        end else if (accept) begin
            shreg     <= {SYNC, wr_addr};
            data_hold <= wr_data;
            bit_idx   <= '0;
            byte_sel  <= 1'b0;
        end else if (boundary) begin
            case (state)
                ST_START: bit_idx <= '0;
                ST_DATA: begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
                ST_STOP: begin
                    if (!byte_sel) begin
                        shreg    <= data_hold;
                        byte_sel <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_apu_serial_tx.sv
// Directed bench for apu_serial_tx with a serial decoder model sampling sdo on sck rising.
module tb_apu_serial_tx;
    import chiptune_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       wr_ready, sck, sdo, busy;

    int checks = 0;
    int errors = 0;
    int glitch = 0;
    int cyc    = 0;

    apu_serial_tx dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .sck      (sck),
        .sdo      (sdo),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Register decoder model
    int         p_pos     = -1;
    logic [7:0] p_sh      = '0;
    logic       p_have0   = 1'b0;
    logic [2:0] p_addr    = '0;
    logic [7:0] regs [8];
    int         frame_err = 0;
    int         n_writes  = 0;
    logic [19:0] cap      = '0;

    always @(posedge sck or posedge rst) begin
        if (rst) begin
            p_pos   <= -1;
            p_have0 <= 1'b0;
        end else begin
            cap <= {cap[18:0], sdo};
            if (p_pos < 0) begin
                if (sdo === 1'b0) p_pos <= 0;
            end else if (p_pos < 8) begin
                p_sh  <= {sdo, p_sh[7:1]};
                p_pos <= p_pos + 1;
            end else begin
                p_pos <= -1;
                if (sdo !== 1'b1) begin
                    frame_err <= frame_err + 1;
                end else if (!p_have0) begin
                    if (p_sh[7:3] == SYNC_MARK) begin
                        p_have0 <= 1'b1;
                        p_addr  <= p_sh[2:0];
                    end else begin
                        frame_err <= frame_err + 1;
                    end
                end else begin
                    p_have0  <= 1'b0;
                    n_writes <= n_writes + 1;
                    if (p_addr < 3'd4) regs[p_addr] <= p_sh;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then settle; flags any sdo change that is not on an sck falling edge.
    task automatic step();
        logic ps, psd;
        ps  = sck;
        psd = sdo;
        @(posedge clk);
        #1;
        cyc++;
        if (!rst && sdo !== psd && !(ps === 1'b1 && sck === 1'b0)) glitch++;
    endtask

    task automatic wait_boundary();
        logic ps;
        for (int i = 0; i < 40; i++) begin
            ps = sck;
            step();
            if (ps === 1'b1 && sck === 1'b0) break;
        end
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (sdo !== 1'b0 && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 1000) begin
            step();
            n++;
        end
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 1000; i++) begin
            if (wr_ready === 1'b1) break;
            step();
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        int n;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        wait_ready();
        step();
        wr_valid = 1'b0;
        wait_idle(n);
        check("write_done", 32'(n < 1000), 32'd1);
    endtask

    initial begin
        int n, t0, t1, t2;
        logic [7:0] save [4];
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;

        // 1: asynchronous reset mid-cycle
        #23 rst = 1'b1;
        #1;
        check("rst_sck", 32'(sck), 32'd0);
        check("rst_sdo", 32'(sdo), 32'd1);
        check("rst_ready", 32'(wr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        step();

        // 2: single write addr=2 data=0x3C
        wr_addr = 3'd2; wr_data = 8'h3C; wr_valid = 1'b1;
        wait_ready();
        step();
        wr_valid = 1'b0;
        wr_addr = 3'd5; wr_data = 8'hFF;
        check("t2_busy_after_accept", 32'(busy), 32'd1);
        wait_start(n);
        check("t2_start_seen", 32'(n < 64), 32'd1);
        wait_idle(n);
        check("t2_busy_len", n, 32'd320);
        check("t2_ready_end", 32'(wr_ready), 32'd1);
        check("t2_bits", 32'(cap), 32'(20'b0010001011_0001111001));
        check("t2_reg2", 32'(regs[2]), 32'h3C);

        // 3a: accept on the boundary edge -> 16 clk latency
        wait_boundary();
        repeat (15) step();
        wr_addr = 3'd1; wr_data = 8'h11; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("t3a_ready_low", 32'(wr_ready), 32'd0);
        wait_start(n);
        check("t3a_latency", n, 32'd16);
        wait_idle(n);

        // 3b: accept one clk before a boundary -> 1 clk latency
        wait_boundary();
        repeat (14) step();
        wr_addr = 3'd3; wr_data = 8'h33; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        check("t3b_ready_low", 32'(wr_ready), 32'd0);
        wait_start(n);
        check("t3b_latency", n, 32'd1);
        wait_idle(n);
        check("t3_regs", 32'({regs[1], regs[3]}), 32'h1133);

        // 4: three back-to-back writes with wr_valid held
        wait_boundary();
        repeat (15) step();
        wr_addr = 3'd0; wr_data = 8'hA5; wr_valid = 1'b1;
        step();
        t0 = cyc;
        wr_addr = 3'd1; wr_data = 8'h5A;
        wait_ready();
        step();
        t1 = cyc;
        wr_addr = 3'd3; wr_data = 8'hC3;
        wait_ready();
        step();
        t2 = cyc;
        wr_valid = 1'b0;
        wr_addr = 3'd0; wr_data = 8'h00;
        wait_idle(n);
        check("t4_gap01", t1 - t0, 32'd336);
        check("t4_gap12", t2 - t1, 32'd336);
        check("t4_reg0", 32'(regs[0]), 32'hA5);
        check("t4_reg1", 32'(regs[1]), 32'h5A);
        check("t4_reg3", 32'(regs[3]), 32'hC3);

        // 5: reset during byte1 data bit 4
        wr_addr = 3'd2; wr_data = 8'h99; wr_valid = 1'b1;
        wait_ready();
        step();
        wr_valid = 1'b0;
        wait_start(n);
        repeat (248) step();
        #2 rst = 1'b1;
        #1;
        check("t5_sdo", 32'(sdo), 32'd1);
        check("t5_sck", 32'(sck), 32'd0);
        check("t5_ready", 32'(wr_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        step();
        check("t5_reg2_kept", 32'(regs[2]), 32'h3C);
        do_write(3'd2, 8'h77);
        check("t5_reg2_new", 32'(regs[2]), 32'h77);

        // 6: loopback register programming
        do_write(3'd0, 8'hBF);
        do_write(3'd1, 8'h08);
        do_write(3'd2, 8'hFD);
        do_write(3'd3, 8'h00);
        check("t6_reg0", 32'(regs[0]), 32'hBF);
        check("t6_reg1", 32'(regs[1]), 32'h08);
        check("t6_reg2", 32'(regs[2]), 32'hFD);
        check("t6_reg3", 32'(regs[3]), 32'h00);
        for (int i = 0; i < 4; i++) save[i] = regs[i];
        n = n_writes;
        do_write(3'd7, 8'h55);
        repeat (16) step();
        check("t6_addr7_decoded", n_writes - n, 32'd1);
        check("t6_regs_unchanged", 32'({regs[0], regs[1], regs[2], regs[3]}),
              32'({save[0], save[1], save[2], save[3]}));
        check("frame_errors", frame_err, 32'd0);
        check("sdo_glitches", glitch, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
